laser_feeder: RTL
=================

# laser_feeder

Host-side transmitter for the LASER circle-placement engine. Buffers one 40-point frame pushed by the host, streams it onto the engine's `X`/`Y` inputs in the exact 40-cycle window the engine samples after each `DONE` pulse, then captures the returned centres `C1X/C1Y/C2X/C2Y` and hands them back to the host over a valid/ready port. It sits between the host/testbench and the LASER engine, and drives every engine input except `CLK`/`RST`.

## Interface
- `NPTS`, 40: points per frame; must equal the engine frame size.
- `TMO_CYC`, 4096: watchdog limit in cycles; used only with the macro.

- `CLK` in 1: clock, shared with the engine.
- `RST` in 1: asynchronous, active-high reset; same net as the engine reset.
- `in_valid` in 1: host point valid.
- `in_ready` out 1: buffer accepts a point.
- `in_x`, `in_y` in 4 each: host point coordinates.
- `X`, `Y` out 4 each: point stream to the engine; registered.
- `DONE` in 1: engine done pulse.
- `C1X`, `C1Y`, `C2X`, `C2Y` in 4 each: engine results; valid in a `DONE`-high cycle.
- `out_valid` out 1: result available.
- `out_ready` in 1: host takes the result.
- `out_c1x`, `out_c1y`, `out_c2x`, `out_c2y` out 4 each: captured centres.
- `busy` out 1: high while in SEND.
- `wdog_err` out 1: sticky watchdog flag.

## Operation
- Buffer: 40 × 8-bit; `wr_cnt` 0..40; full when `wr_cnt == NPTS`.
- `in_ready = !full && state != SEND`. A host write happens when `in_valid && in_ready`; it stores at `wr_cnt` and increments `wr_cnt`.
- FSM states: WAIT and SEND. Reset state is WAIT.
- **WAIT, `DONE==1` (window open):**
  - Capture the results when `pend_real == 1`: `out_*` ← `C*` and `out_valid` ← 1. Then clear `pend_real`.
  - Decide the frame type:
    - Real frame: `full && (!out_valid || out_ready)`, with `out_valid` taken before this cycle's capture.
    - Otherwise a dummy frame of 40 zeros.
  - Go to SEND, `rd_cnt` ← 0, `cur_real` ← frame type.
- **SEND:**
  - Drive `X`/`Y` ← `buf[rd_cnt]` (zeros for a dummy frame); `rd_cnt++`.
  - After `rd_cnt == NPTS-1`, go to WAIT. Set `pend_real` ← `cur_real`. For a real frame, `wr_cnt` ← 0.
- `DONE` during SEND is ignored.
- `out_valid` clears on `out_valid && out_ready`, unless a capture occurs in the same cycle.
- A dummy frame's result is always discarded.

## Timing
- Reset values:
  - `X`, `Y`, `out_*`, `out_valid`, `busy`, `wdog_err` = 0.
  - `wr_cnt`, `rd_cnt` = 0; `pend_real`, `cur_real` = 0.
- Cycle d has `DONE` high in WAIT. Point k appears on `X`/`Y` during cycle d+1+k, k = 0..39. `X`/`Y` return to 0 in cycle d+41.
- After reset release the engine's `DONE` is still high in the first cycle. That cycle is a window; with an empty buffer it yields a dummy frame.
- A result captured in cycle d gives `out_valid` high from cycle d+1.
- The capture and the next window open in the same `DONE` cycle.
- Simultaneous events:
  - A host write in the last SEND cycle is blocked, because `in_ready` is low.
  - An `out_ready` accept in a `DONE` cycle frees the slot for a real frame.
- Reset mid-SEND: stream aborted, `X`/`Y` forced to 0 asynchronously, buffer contents discarded (`wr_cnt` = 0).

## Configuration
- `LASER_FEEDER_WDOG_EN` defined:
  - A 16-bit counter runs in WAIT while `pend_real == 1`.
  - When it reaches `TMO_CYC`, `wdog_err` goes to 1 (sticky until reset) and `pend_real` clears.
  - The counter clears on `DONE`.
- Undefined: no counter; `wdog_err` tied to 0.

## Structure
- Shared package `laser_pkg`:
  - `LASER_NPTS = 40`, `LASER_CW = 4` (coordinate width).
  - Typedef `laser_pt_t` (x,y) and typedef `laser_res_t` (c1x,c1y,c2x,c2y).
- One sub-module `laser_pt_buf`: the 40-entry point buffer with `wr_cnt`/full logic. The FSM, capture and watchdog stay in `laser_feeder`.

## Test plan
- Reset, no host writes, `DONE` high in the first cycle → 40 cycles of `X`=`Y`=0, `busy`=1 for 40 cycles, `out_valid` stays 0.
- Load 40 points (i%16, (3·i)%16). Pulse `DONE` at cycle d → `X`=i%16 and `Y`=(3·i)%16 in cycle d+1+i; `in_ready`=0 throughout.
- After a real frame, pulse `DONE` with C1=(5,6), C2=(9,10) → `out_valid`=1 next cycle with those values; `out_ready`=1 clears it.
- Result pending (`out_ready`=0) and buffer full at `DONE` → dummy frame sent, `wr_cnt` stays 40; the next `DONE` result is discarded and `out_*` are unchanged.
- Assert `RST` at SEND point 20 → `X`/`Y`=0 immediately, `busy`=0, `in_ready`=1 after release, `wr_cnt`=0.
- With `LASER_FEEDER_WDOG_EN`, `TMO_CYC`=100, send a real frame and withhold `DONE` → `wdog_err`=1 at 100 cycles, stays 1, and a later `DONE` produces no `out_valid`.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and sizes for the LASER engine host-side interface.
package laser_pkg;
    localparam int LASER_NPTS = 40;
    localparam int LASER_CW   = 4;

    typedef struct packed {
        logic [LASER_CW-1:0] x;
        logic [LASER_CW-1:0] y;
    } laser_pt_t;

    typedef struct packed {
        logic [LASER_CW-1:0] c1x;
        logic [LASER_CW-1:0] c1y;
        logic [LASER_CW-1:0] c2x;
        logic [LASER_CW-1:0] c2y;
    } laser_res_t;

    typedef enum logic {ST_WAIT, ST_SEND} laser_st_t;
endpackage

// File: rtl/laser_pt_buf.sv
// One-frame point buffer: sequential writes from the host, random read by the streamer.
module laser_pt_buf
    import laser_pkg::*;
#(
    parameter int NPTS = LASER_NPTS,
    localparam int AW  = $clog2(NPTS + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  laser_pt_t     wr_pt,
    input  logic          clr,
    input  logic [AW-1:0] rd_idx,
    output laser_pt_t     rd_pt,
    output logic          full
);
    laser_pt_t     mem [NPTS];
    logic [AW-1:0] wr_cnt;

    assign full  = (wr_cnt == AW'(NPTS));
    assign rd_pt = mem[rd_idx];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            wr_cnt <= '0;
        else if (clr)
            wr_cnt <= '0;
        else if (wr_en && !full)
            wr_cnt <= wr_cnt + 1'b1;
    end

    // Storage is not reset; wr_cnt alone says what is valid.
    always_ff @(posedge CLK) begin
        if (wr_en && !full)
            mem[wr_cnt] <= wr_pt;
    end
endmodule

// File: rtl/laser_feeder.sv
// Streams a buffered 40-point frame into the LASER engine after each DONE and returns its centres.
// Optional watchdog on a missing DONE: define LASER_FEEDER_WDOG_EN.
module laser_feeder
    import laser_pkg::*;
#(
    parameter int NPTS    = LASER_NPTS,
    parameter int TMO_CYC = 4096
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LASER_CW-1:0] in_x,
    input  logic [LASER_CW-1:0] in_y,
    output logic [LASER_CW-1:0] X,
    output logic [LASER_CW-1:0] Y,
    input  logic                DONE,
    input  logic [LASER_CW-1:0] C1X,
    input  logic [LASER_CW-1:0] C1Y,
    input  logic [LASER_CW-1:0] C2X,
    input  logic [LASER_CW-1:0] C2Y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LASER_CW-1:0] out_c1x,
    output logic [LASER_CW-1:0] out_c1y,
    output logic [LASER_CW-1:0] out_c2x,
    output logic [LASER_CW-1:0] out_c2y,
    output logic                busy,
    output logic                wdog_err
);
    localparam int AW = $clog2(NPTS + 1);

    laser_st_t     state, state_nx;
    logic [AW-1:0] rd_cnt, rd_idx;
    logic          cur_real, pend_real;
    logic          win, last, real_go, capture, wdog_to, full;
    laser_pt_t     rd_pt;
    laser_res_t    out_res;

    laser_pt_buf #(.NPTS(NPTS)) u_buf (
        .CLK    (CLK),
        .RST    (RST),
        .wr_en  (in_valid && in_ready),
        .wr_pt  ('{x: in_x, y: in_y}),
        .clr    (last && cur_real),
        .rd_idx (rd_idx),
        .rd_pt  (rd_pt),
        .full   (full)
    );

    assign in_ready = !full && (state != ST_SEND);
    assign busy     = (state == ST_SEND);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_WAIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        win      = 1'b0;
        last     = 1'b0;
        case (state)
            ST_WAIT: if (DONE) begin
                win      = 1'b1;
                state_nx = ST_SEND;
            end
            ST_SEND: if (rd_cnt == AW'(NPTS - 1)) begin
                last     = 1'b1;
                state_nx = ST_WAIT;
            end
            default: state_nx = ST_WAIT;
        endcase
        // out_valid here is the pre-capture value, so an accept this cycle frees the slot
        real_go = full && (!out_valid || out_ready);
        capture = win && pend_real;
        // X/Y are registered, so fetch one point ahead of the one on the wire
        rd_idx  = win ? '0 : rd_cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_cnt   <= '0;
            cur_real <= 1'b0;
            X        <= '0;
            Y        <= '0;
        end else if (win) begin
            rd_cnt   <= '0;
            cur_real <= real_go;
            X        <= real_go ? rd_pt.x : '0;
            Y        <= real_go ? rd_pt.y : '0;
        end else if (last) begin
            rd_cnt   <= '0;
            X        <= '0;
            Y        <= '0;
        end else if (state == ST_SEND) begin
            rd_cnt   <= rd_cnt + 1'b1;
            X        <= cur_real ? rd_pt.x : '0;
            Y        <= cur_real ? rd_pt.y : '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_real <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
        end else begin
            if (capture || wdog_to)
                pend_real <= 1'b0;
            else if (last)
                pend_real <= cur_real;
            if (capture) begin
                out_res   <= '{c1x: C1X, c1y: C1Y, c2x: C2X, c2y: C2Y};
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_c1x = out_res.c1x;
    assign out_c1y = out_res.c1y;
    assign out_c2x = out_res.c2x;
    assign out_c2y = out_res.c2y;

`ifdef LASER_FEEDER_WDOG_EN
    logic [15:0] wdog_cnt;

    assign wdog_to = (state == ST_WAIT) && pend_real && !DONE && (wdog_cnt == 16'(TMO_CYC - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (DONE || wdog_to)
                wdog_cnt <= '0;
            else if ((state == ST_WAIT) && pend_real)
                wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_to)
                wdog_err <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TMO_CYC);
    assign wdog_to    = 1'b0;
    assign wdog_err   = 1'b0;
`endif
endmodule
